// File: rtl/mips_pkg.sv
//============================================================================
// Module  : mips_pkg
// Brief   : Shared definitions for the ID/EX stage: packed control word
//           layout, return-address register index, forwarding selects.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package mips_pkg;

    localparam int ALUOP_WIDTH = 6;
    localparam int CTRL_WIDTH  = ALUOP_WIDTH + 9;

    // Bit positions inside the packed control word (LSB first)
    localparam int CTRL_MEMWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_JUMP      = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ISSIGNED  = 5;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_REGDEST   = 7;
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_ALUOP_LSB = 9;

    // jal writes its link address here
    localparam int REG_RA = 31;

    // Operand source selects presented to EX
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EXMEM   = 2'b01,
        FWD_MEMWB   = 2'b10
    } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
//============================================================================
// Module  : hazard_unit
// Brief   : Combinational hazard detection and forwarding select for the
//           instruction sitting in ID. Compile-time option ID_EX_FWD_EN
//           selects forwarding (only load-use interlocks) versus a full
//           RAW interlock with no forwarding.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_mem_read,
    input  logic                      ex_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    output logic                      hazard,
    output fwd_sel_e                  fwd_a,
    output fwd_sel_e                  fwd_b
);

    // Register 0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [REG_ADDR_WIDTH-1:0] dst,
                                       input logic [REG_ADDR_WIDTH-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_load_use;

    assign w_ex_rs    = reg_match(ex_dest, id_rs);
    assign w_ex_rt    = reg_match(ex_dest, id_rt);
    assign w_mem_rs   = reg_match(mem_dest, id_rs);
    assign w_mem_rt   = reg_match(mem_dest, id_rt);
    assign w_load_use = ex_mem_read && (w_ex_rs || w_ex_rt);

`ifdef ID_EX_FWD_EN
    // Youngest writer wins: the EX occupant becomes EX/MEM, the MEM occupant becomes MEM/WB
    always_comb begin
        hazard = w_load_use;
        fwd_a  = FWD_REGFILE;
        fwd_b  = FWD_REGFILE;
        if (ex_reg_write && w_ex_rs)
            fwd_a = FWD_EXMEM;
        else if (mem_reg_write && w_mem_rs)
            fwd_a = FWD_MEMWB;
        if (ex_reg_write && w_ex_rt)
            fwd_b = FWD_EXMEM;
        else if (mem_reg_write && w_mem_rt)
            fwd_b = FWD_MEMWB;
    end
`else
    // No bypass paths: interlock until the producer reaches WB (write-through regfile)
    always_comb begin
        hazard = w_load_use
              || (ex_reg_write  && (w_ex_rs  || w_ex_rt))
              || (mem_reg_write && (w_mem_rs || w_mem_rt));
        fwd_a  = FWD_REGFILE;
        fwd_b  = FWD_REGFILE;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with hold/flush/bubble priority and
//           the stall output to PC and IF/ID. Optional forwarding selects
//           are enabled by defining ID_EX_FWD_EN.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALUOP_WIDTH+8:0]    id_ctrl,
    input  logic                      id_jal,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dest,
    output logic                      stall,
    output logic [ALUOP_WIDTH+8:0]    ex_ctrl,
    output logic                      ex_jal,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic [1:0]                ex_fwd_a,
    output logic [1:0]                ex_fwd_b
);

    localparam int CTRL_W = ALUOP_WIDTH + 9;

    logic [CTRL_W-1:0]         r_ctrl;
    logic                      r_jal;
    logic [DATA_WIDTH-1:0]     r_rs_data, r_rt_data, r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs, r_rt, r_dest;
    logic [1:0]                r_fwd_a, r_fwd_b;

    logic                      w_hazard;
    fwd_sel_e                  w_fwd_a, w_fwd_b;
    logic [REG_ADDR_WIDTH-1:0] w_load_dest;
    logic                      w_wb_unused;

    // The regfile writes through, so the WB writer is visible in ID already
    assign w_wb_unused = wb_reg_write ^ (^wb_dest);

    hazard_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_unit (
        .ex_mem_read   (r_ctrl[CTRL_MEMREAD]),
        .ex_reg_write  (r_ctrl[CTRL_REGWRITE]),
        .ex_dest       (r_dest),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .hazard        (w_hazard),
        .fwd_a         (w_fwd_a),
        .fwd_b         (w_fwd_b)
    );

    assign w_load_dest = id_jal                 ? REG_ADDR_WIDTH'(REG_RA) :
                         id_ctrl[CTRL_REGDEST]  ? id_rd : id_rt;

    // A flushed ID instruction dies, so it need not be re-presented
    assign stall = !rst && (hold || (!flush && w_hazard));

    // Pipeline register: hold > flush > hazard bubble > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_jal     <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_fwd_a   <= FWD_REGFILE;
            r_fwd_b   <= FWD_REGFILE;
        end else if (hold) begin
            r_ctrl <= r_ctrl;
        end else if (flush || w_hazard) begin
            r_ctrl    <= '0;
            r_jal     <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_fwd_a   <= FWD_REGFILE;
            r_fwd_b   <= FWD_REGFILE;
        end else begin
            r_ctrl    <= id_ctrl;
            r_jal     <= id_jal;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_dest    <= w_load_dest;
            r_fwd_a   <= w_fwd_a;
            r_fwd_b   <= w_fwd_b;
        end
    end

    assign ex_ctrl    = r_ctrl;
    assign ex_jal     = r_jal;
    assign ex_rs_data = r_rs_data;
    assign ex_rt_data = r_rt_data;
    assign ex_imm     = r_imm;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_dest    = r_dest;
    assign ex_fwd_a   = r_fwd_a;
    assign ex_fwd_b   = r_fwd_b;

endmodule

`default_nettype wire
